// File: rtl/onchip_ram_pkg.sv
// Shared types for onchip_ram_pipe: FSM states, legal read latencies and the
// build switch for the power-up clear sequence (macro ONCHIP_RAM_CLEAR_EN).
package onchip_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RL_ONE = 1;
  localparam int RL_TWO = 2;

`ifdef ONCHIP_RAM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_array.sv
// Byte-enabled single-port storage with a registered, read-enabled output.
// Preload from INIT_FILE only applies when ONCHIP_RAM_CLEAR_EN is not defined.
module onchip_ram_array
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 13,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  localparam int NB    = lane_count(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NB-1:0] lane_we;

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_we[gi] = we & be[gi];
  end

  // q only moves on an accepted read, so it doubles as the held read result.
  if (!CLEAR_EN && INIT_FILE != "") begin : g_preload
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++)
        if (lane_we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      if (re) q <= mem[addr];
    end
  end else begin : g_plain
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++)
        if (lane_we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      if (re) q <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_pipe.sv
// Avalon-MM on-chip RAM with 1- or 2-cycle pipelined reads and a global clock
// enable. Define ONCHIP_RAM_CLEAR_EN to zero the whole array after every reset.
module onchip_ram_pipe
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 13,
  parameter int    READ_LATENCY = RL_ONE,
  parameter string INIT_FILE    = "onchip_ram_pipe.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  localparam int NB = lane_count(DATA_W);

`ifdef ONCHIP_RAM_CLEAR_EN
  localparam ram_state_e RESET_STATE = CLEAR;
`else
  localparam ram_state_e RESET_STATE = READY;
`endif

  ram_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
  logic              clr_we;
  logic              accept, wr_acc, rd_acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= RESET_STATE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    clr_we        = 1'b0;
    if (state_reg == CLEAR && clken) begin
      clr_we        = 1'b1;
      clr_addr_next = clr_addr_reg + ADDR_W'(1);
      if (clr_addr_reg == '1) state_next = READY;
    end
  end

  assign waitrequest = (state_reg != READY) | ~clken;
  assign init_done   = (state_reg == READY);

  // A simultaneous read+write is treated as a write; the read is dropped.
  assign accept = chipselect & clken & ~waitrequest;
  assign wr_acc = accept & write;
  assign rd_acc = accept & read & ~write;

  assign ram_we    = clr_we | wr_acc;
  assign ram_addr  = clr_we ? clr_addr_reg : address;
  assign ram_be    = clr_we ? '1 : byteenable;
  assign ram_wdata = clr_we ? '0 : writedata;

  onchip_ram_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (rd_acc),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  if (READ_LATENCY == RL_TWO) begin : g_lat2
    logic              stage1_reg, rdv_reg;
    logic [DATA_W-1:0] data_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage1_reg <= 1'b0;
        rdv_reg    <= 1'b0;
        data_reg   <= '0;
      end else if (clken) begin
        stage1_reg <= rd_acc;
        rdv_reg    <= stage1_reg;
        if (stage1_reg) data_reg <= ram_q;
      end
    end
    assign readdatavalid = rdv_reg & clken;
    assign readdata      = data_reg;
  end else begin : g_lat1
    // The RAM output register cannot be reset, so mask it until the first pulse.
    logic rdv_reg, seen_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdv_reg  <= 1'b0;
        seen_reg <= 1'b0;
      end else if (clken) begin
        rdv_reg  <= rd_acc;
        seen_reg <= seen_reg | rdv_reg;
      end
    end
    assign readdatavalid = rdv_reg & clken;
    assign readdata      = (rdv_reg | seen_reg) ? ram_q : '0;
  end

endmodule

// File: tb/tb_onchip_ram_pipe.sv
// Scoreboard bench for onchip_ram_pipe (READ_LATENCY=2, ADDR_W=4); the clear
// scenarios run only when ONCHIP_RAM_CLEAR_EN is defined.
module tb_onchip_ram_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int RL     = 2;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic [NB-1:0]     byteenable = '0;
  logic              chipselect = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [DATA_W-1:0] writedata = '0;
  logic              clken = 1'b1;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;
  logic              init_done;

  onchip_ram_pipe #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (RL),
    .INIT_FILE    ("")
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .clken         (clken),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks_total = 0;
  int   checks_pass  = 0;
  int   rdv_count    = 0;

  // Every readdatavalid pulse must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    if (reset_n && readdatavalid) begin
      rdv_count++;
      checks_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rdv: got pulse data=%h at cycle %0d, required no pulse", readdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (readdata !== mon_e.data || cyc != mon_e.due)
          $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                   readdata, cyc, mon_e.data, mon_e.due);
        else
          checks_pass++;
      end
    end
  end

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
  endtask

  task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [NB-1:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    #1;
    checks_total++;
    if (waitrequest !== 1'b0) $display("FAIL write_wait: waitrequest=%b required 0", waitrequest);
    else checks_pass++;
    @(negedge clk);
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expd);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    exp_q.push_back('{expd, cyc + RL});
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
      exp_q.delete();
    end else checks_pass++;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && init_done !== 1'b1; i++) @(negedge clk);
    checks_total++;
    if (init_done !== 1'b1) $display("FAIL ready_timeout: init_done=%b required 1", init_done);
    else checks_pass++;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    @(negedge clk);
    checks_total += 2;
    if (readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b required 0", readdatavalid);
    else checks_pass++;
    if (readdata !== '0) $display("FAIL reset_rdata: got %h required 0", readdata);
    else checks_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks_total += 2;
`ifdef ONCHIP_RAM_CLEAR_EN
    if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b required 0", init_done);
    else checks_pass++;
    if (waitrequest !== 1'b1) $display("FAIL reset_wait: got %b required 1", waitrequest);
    else checks_pass++;
    wait_ready();
`else
    if (init_done !== 1'b1) $display("FAIL reset_init_done: got %b required 1", init_done);
    else checks_pass++;
    if (waitrequest !== 1'b0) $display("FAIL reset_wait: got %b required 0", waitrequest);
    else checks_pass++;
    clken = 1'b0;
    #1;
    checks_total++;
    if (waitrequest !== 1'b1) $display("FAIL clken_wait: got %b required 1", waitrequest);
    else checks_pass++;
    clken = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_byte_enable();
    issue_write(4'd5, 32'hDEADBEEF, 4'hF);
    issue_write(4'd5, 32'h000000AA, 4'h1);
    issue_read(4'd5, 32'hDEADBEAA);
    issue_write(4'd6, 32'h11223344, 4'hF);
    issue_write(4'd6, 32'hAABBCCDD, 4'hA);
    issue_read(4'd6, 32'hAA22CC44);
    issue_write(4'd6, 32'h55555555, 4'h0);
    issue_read(4'd6, 32'hAA22CC44);
    drain();
    repeat (2) @(negedge clk);
    checks_total++;
    if (readdata !== 32'hAA22CC44) $display("FAIL rdata_hold: got %h required aa22cc44", readdata);
    else checks_pass++;
  endtask

  task automatic test_back_to_back();
    issue_write(4'd0, 32'h0A0A0A0A, 4'hF);
    issue_write(4'd1, 32'h1B1B1B1B, 4'hF);
    issue_write(4'd2, 32'h2C2C2C2C, 4'hF);
    issue_read(4'd0, 32'h0A0A0A0A);
    issue_read(4'd1, 32'h1B1B1B1B);
    issue_read(4'd2, 32'h2C2C2C2C);
    drain();
  endtask

  task automatic test_rw_collision();
    int snap;
    snap = rdv_count;
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 4'd7; writedata = 32'h12345678; byteenable = 4'hF;
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    checks_total++;
    if (rdv_count != snap) $display("FAIL rw_dropped_read: got %0d pulses required 0", rdv_count - snap);
    else checks_pass++;
    issue_read(4'd7, 32'h12345678);
    drain();
  endtask

  task automatic test_clken_freeze();
    issue_write(4'd3, 32'hCAFEF00D, 4'hF);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 4'd3;
    exp_q.push_back('{32'hCAFEF00D, cyc + RL + 3});
    @(negedge clk);
    idle();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks_total += 2;
      if (waitrequest !== 1'b1) $display("FAIL freeze_wait: got %b required 1", waitrequest);
      else checks_pass++;
      if (readdatavalid !== 1'b0) $display("FAIL freeze_rdv: got %b required 0", readdatavalid);
      else checks_pass++;
      @(negedge clk);
    end
    clken = 1'b1;
    drain();
  endtask

  task automatic test_reset_flush();
    int snap;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 4'd3;
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    snap = rdv_count;
    #1;
    checks_total += 2;
    if (readdatavalid !== 1'b0) $display("FAIL flush_rdv: got %b required 0", readdatavalid);
    else checks_pass++;
    if (readdata !== '0) $display("FAIL flush_rdata: got %h required 0", readdata);
    else checks_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready();
    repeat (5) @(negedge clk);
    checks_total++;
    if (rdv_count != snap) $display("FAIL flush_pulse: got %0d pulses required 0", rdv_count - snap);
    else checks_pass++;
  endtask

`ifdef ONCHIP_RAM_CLEAR_EN
  task automatic fill_and_reset();
    for (int i = 0; i < DEPTH; i++) issue_write(ADDR_W'(i), 32'h01010101 * (i + 1), 4'hF);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic count_clear(input string name);
    int n;
    bit wait_bad;
    n = 0;
    wait_bad = 1'b0;
    while (init_done !== 1'b1 && n < 40) begin
      if (waitrequest !== 1'b1) wait_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks_total += 2;
    if (n != DEPTH) $display("FAIL %s_cycles: got %0d required %0d", name, n, DEPTH);
    else checks_pass++;
    if (wait_bad) $display("FAIL %s_wait: got waitrequest=0 during clear required 1", name);
    else checks_pass++;
    for (int i = 0; i < DEPTH; i++) issue_read(ADDR_W'(i), 32'h00000000);
    drain();
  endtask

  task automatic test_clear();
    fill_and_reset();
    count_clear("clear");
  endtask

  task automatic test_clear_restart();
    fill_and_reset();
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks_total++;
    if (init_done !== 1'b0) $display("FAIL restart_init_done: got %b required 0", init_done);
    else checks_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    count_clear("restart");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_rw_collision();
    test_clken_freeze();
    test_reset_flush();
`ifdef ONCHIP_RAM_CLEAR_EN
    test_clear();
    test_clear_restart();
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
